// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C master: FSM states,
// quarter-phase encodings and R/W bit values.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_NACK,
        STOP,
        DONE
    } state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_clk_gen.sv
// Quarter-period tick generator for the I2C master: qtick every CLK_DIV cycles
// while enabled, with a 2-bit phase. I2C_MASTER_STRETCH_EN adds a stall input.
module i2c_clk_gen
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
`ifdef I2C_MASTER_STRETCH_EN
    input  logic       i_stall,
`endif
    output logic       o_qtick,
    output logic [1:0] o_phase
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_phase;
    logic          w_run;

`ifdef I2C_MASTER_STRETCH_EN
    assign w_run = i_en && !i_stall;
`else
    assign w_run = i_en;
`endif

    assign o_qtick = w_run && (r_cnt == CNT_MAX);
    assign o_phase = r_phase;

    // Counter and phase both return to zero whenever the master is idle.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
            r_cnt   <= '0;
            r_phase <= Q0;
        end else if (w_run) begin
            if (r_cnt == CNT_MAX) begin
                r_cnt   <= '0;
                r_phase <= r_phase + 2'd1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C master: START, address+R/W, ACK check, one data byte, STOP.
// Define I2C_MASTER_STRETCH_EN for open-drain SCL with slave clock stretching.
module i2c_master
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    inout  wire        scl,
    inout  wire        sda
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_bitcnt;
    logic [7:0] r_addr_rw;
    logic [7:0] r_wdata;
    logic [7:0] r_shift;
    logic       r_ack_smp;
    logic [7:0] r_rdata;
    logic       r_ack_err;

    logic       w_qtick;
    logic [1:0] w_phase;
    logic       w_last_q;
    logic       w_smp_q;
    logic       w_accept;
    logic       w_bit_scl;
    logic       w_scl_hi;
    logic       w_sda_low;
    logic       w_sda_in;

    assign w_accept  = start && (r_state == IDLE);
    assign w_last_q  = w_qtick && (w_phase == Q3);
    assign w_smp_q   = w_qtick && (w_phase == Q2);
    assign w_bit_scl = (w_phase == Q1) || (w_phase == Q2);
    assign w_sda_in  = sda;

    assign busy    = (r_state != IDLE);
    assign done    = (r_state == DONE);
    assign rdata   = r_rdata;
    assign ack_err = r_ack_err;

`ifdef I2C_MASTER_STRETCH_EN
    logic w_stall;
    // A slave holding SCL low while we release it freezes the bit timing.
    assign w_stall = w_bit_scl && (scl == 1'b0);
    assign scl     = w_scl_hi ? 1'bz : 1'b0;

    i2c_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_en    (busy),
        .i_stall (w_stall),
        .o_qtick (w_qtick),
        .o_phase (w_phase)
    );
`else
    assign scl = w_scl_hi;

    i2c_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_en    (busy),
        .o_qtick (w_qtick),
        .o_phase (w_phase)
    );
`endif

    assign sda = w_sda_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_scl_hi    = 1'b1;
        w_sda_low   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = START;
            end
            START: begin
                w_scl_hi  = (w_phase != Q3);
                w_sda_low = (w_phase != Q0);
                if (w_last_q) w_state_nxt = ADDR;
            end
            ADDR: begin
                w_scl_hi  = w_bit_scl;
                w_sda_low = !r_addr_rw[3'd7 - r_bitcnt];
                if (w_last_q && (r_bitcnt == 3'd7)) w_state_nxt = ADDR_ACK;
            end
            ADDR_ACK: begin
                w_scl_hi = w_bit_scl;
                if (w_last_q) begin
                    if (r_ack_smp)                       w_state_nxt = STOP;
                    else if (r_addr_rw[0] == I2C_RW_READ) w_state_nxt = READ;
                    else                                  w_state_nxt = WRITE;
                end
            end
            WRITE: begin
                w_scl_hi  = w_bit_scl;
                w_sda_low = !r_wdata[3'd7 - r_bitcnt];
                if (w_last_q && (r_bitcnt == 3'd7)) w_state_nxt = WRITE_ACK;
            end
            WRITE_ACK: begin
                w_scl_hi = w_bit_scl;
                if (w_last_q) w_state_nxt = STOP;
            end
            READ: begin
                w_scl_hi = w_bit_scl;
                if (w_last_q && (r_bitcnt == 3'd7)) w_state_nxt = READ_NACK;
            end
            READ_NACK: begin
                w_scl_hi = w_bit_scl;
                if (w_last_q) w_state_nxt = STOP;
            end
            STOP: begin
                // SDA rises while SCL is high, after being held low through Q1.
                w_scl_hi  = (w_phase != Q0);
                w_sda_low = (w_phase == Q0) || (w_phase == Q1);
                if (w_last_q) w_state_nxt = DONE;
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bitcnt  <= 3'd0;
            r_rdata   <= 8'h00;
            r_ack_err <= 1'b0;
        end else begin
            if (r_state == IDLE) begin
                r_bitcnt <= 3'd0;
            end else if (w_last_q && ((r_state == ADDR) || (r_state == WRITE) ||
                                      (r_state == READ))) begin
                r_bitcnt <= r_bitcnt + 3'd1;
            end

            if (w_accept) begin
                r_ack_err <= 1'b0;
            end else if (w_last_q && r_ack_smp &&
                         ((r_state == ADDR_ACK) || (r_state == WRITE_ACK))) begin
                r_ack_err <= 1'b1;
            end

            if (w_last_q && (r_state == READ_NACK)) begin
                r_rdata <= r_shift;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr_rw <= {addr, rw};
            r_wdata   <= wdata;
        end
        if (w_smp_q) begin
            r_ack_smp <= w_sda_in;
            if (r_state == READ) begin
                r_shift <= {r_shift[6:0], w_sda_in};
            end
        end
    end

endmodule

// File: tb/tb_i2c_master.sv
// Self-checking bench for i2c_master: vector table, bus monitor scoreboard,
// behavioural slave at 0x50, plus busy-start, mid-transfer reset and stretching.
module tb_i2c_master;

    localparam int CLK_DIV = 4;
    localparam logic [6:0] SLV_ADDR = 7'h50;
    localparam logic [3:0] EV_START = 4'd1;
    localparam logic [3:0] EV_BYTE  = 4'd2;
    localparam logic [3:0] EV_ACK   = 4'd3;
    localparam logic [3:0] EV_STOP  = 4'd4;

    typedef struct {
        logic [6:0] a;
        logic       r;
        logic [7:0] wd;
        logic [7:0] rd;
        logic [7:0] exp_rdata;
        logic       exp_err;
        int         lat;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [6:0] addr = 7'h00;
    logic       rw = 1'b0;
    logic [7:0] wdata = 8'h00;
    wire  [7:0] rdata;
    wire        busy;
    wire        done;
    wire        ack_err;
    wire        scl;
    wire        sda;

    pullup (scl);
    pullup (sda);

    logic sl_sda_low = 1'b0;
    assign sda = sl_sda_low ? 1'b0 : 1'bz;
`ifdef I2C_MASTER_STRETCH_EN
    logic sl_scl_low = 1'b0;
    bit   stretch_on = 1'b0;
    assign scl = sl_scl_low ? 1'b0 : 1'bz;
`endif

    i2c_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .addr    (addr),
        .rw      (rw),
        .wdata   (wdata),
        .rdata   (rdata),
        .busy    (busy),
        .done    (done),
        .ack_err (ack_err),
        .scl     (scl),
        .sda     (sda)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int done_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    int n_vec = 0;
    int n_err = 0;
    int t0 = 0;
    logic [11:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic observe(input logic [3:0] tag, input logic [7:0] val);
        logic [11:0] e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL bus_event: got tag %0d val %02h with none expected", tag, val);
        end else begin
            e = exp_q.pop_front();
            if (e !== {tag, val}) begin
                n_err++;
                $display("FAIL bus_event: got tag %0d val %02h expected tag %0d val %02h",
                         tag, val, e[11:8], e[7:0]);
            end
        end
    endtask

    // Bus monitor and slave model share one block so sampling precedes driving.
    bit         m_pscl = 1'b1;
    bit         m_psda = 1'b1;
    bit         m_act = 1'b0;
    int         m_bits = 0;
    logic [7:0] m_byte = 8'h00;
    int         rises = 0;
    int         sl_st = 0;
    int         sl_cnt = 0;
    logic [7:0] sl_sh = 8'h00;
    logic [7:0] sl_rd = 8'h00;
    logic       sl_rw = 1'b0;

    always @(negedge clk) begin
        if (m_pscl && scl && m_psda && !sda) begin
            observe(EV_START, 8'h00);
            m_act = 1'b1; m_bits = 0;
            sl_st = 1; sl_cnt = 0; sl_sda_low = 1'b0;
        end else if (m_pscl && scl && !m_psda && sda) begin
            observe(EV_STOP, 8'h00);
            m_act = 1'b0;
            sl_st = 0; sl_sda_low = 1'b0;
        end else if (!m_pscl && scl) begin
            rises++;
            if (m_act) begin
                if (m_bits == 8) begin
                    observe(EV_ACK, {7'd0, sda});
                    m_bits = 0;
                end else begin
                    m_byte = {m_byte[6:0], sda};
                    m_bits++;
                    if (m_bits == 8) observe(EV_BYTE, m_byte);
                end
            end
            if (sl_st == 1 || sl_st == 3) begin
                sl_sh = {sl_sh[6:0], sda};
                sl_cnt++;
            end else if (sl_st == 5) begin
                sl_cnt++;
            end
        end else if (m_pscl && !scl) begin
            case (sl_st)
                1: if (sl_cnt == 8) begin
                    if (sl_sh[7:1] == SLV_ADDR) begin
                        sl_sda_low = 1'b1; sl_rw = sl_sh[0]; sl_st = 2;
                    end else begin
                        sl_st = 0;
                    end
                end
                2: begin
                    sl_cnt = 0;
                    if (sl_rw) begin sl_st = 5; sl_sda_low = !sl_rd[7]; end
                    else       begin sl_st = 3; sl_sda_low = 1'b0; end
                end
                3: if (sl_cnt == 8) begin sl_sda_low = 1'b1; sl_st = 4; end
                4: begin sl_sda_low = 1'b0; sl_st = 0; end
                5: if (sl_cnt == 8) begin sl_sda_low = 1'b0; sl_st = 0; end
                   else sl_sda_low = !sl_rd[7 - sl_cnt];
                default: ;
            endcase
        end
        m_pscl = scl;
        m_psda = sda;
`ifdef I2C_MASTER_STRETCH_EN
        if (stretch_on && (cyc - t0 == 164)) sl_scl_low = 1'b1;
        if (stretch_on && (cyc - t0 == 185)) begin sl_scl_low = 1'b0; stretch_on = 1'b0; end
`endif
    end

    task automatic launch(input logic [6:0] a, input logic r, input logic [7:0] wd,
                          input logic [7:0] rd);
        bit acked;
        acked = (a == SLV_ADDR);
        sl_rd = rd;
        exp_q.push_back({EV_START, 8'h00});
        exp_q.push_back({EV_BYTE, a, r});
        exp_q.push_back({EV_ACK, 7'd0, !acked});
        if (acked) begin
            exp_q.push_back({EV_BYTE, (r ? rd : wd)});
            exp_q.push_back({EV_ACK, 7'd0, r});
        end
        exp_q.push_back({EV_STOP, 8'h00});
        @(negedge clk);
        addr = a; rw = r; wdata = wd; start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        bit got;
        int n;
        got = 1'b0;
        n = 0;
        while (!got && n < 3000) begin
            if (done) got = 1'b1;
            else begin @(negedge clk); n++; end
        end
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL done_timeout: got no done within %0d cycles, required one", n);
        end
        lat = cyc - t0;
    endtask

    task automatic run_vec(input vec_t v);
        int lat, r0, d0;
        r0 = rises;
        d0 = done_cnt;
        launch(v.a, v.r, v.wd, v.rd);
        wait_done(lat);
        chk("latency", lat, v.lat);
        chk("rdata", rdata, v.exp_rdata);
        chk("ack_err", ack_err, v.exp_err);
        @(negedge clk);
        chk("busy_after_done", busy, 0);
        chk("done_pulses", done_cnt - d0, 1);
        chk("bus_events_left", exp_q.size(), 0);
        chk("scl_rises", rises - r0, (v.a == SLV_ADDR) ? 19 : 10);
    endtask

    vec_t tbl[7];
    vec_t v;

    initial begin
        int lat, d0;
        tbl = '{
            '{7'h50, 1'b0, 8'hA5, 8'h00, 8'h00, 1'b0, 321},
            '{7'h50, 1'b1, 8'h00, 8'h3C, 8'h3C, 1'b0, 321},
            '{7'h27, 1'b0, 8'h00, 8'h00, 8'h3C, 1'b1, 177},
            '{7'h50, 1'b0, 8'h00, 8'h00, 8'h3C, 1'b0, 321},
            '{7'h50, 1'b1, 8'h00, 8'h81, 8'h81, 1'b0, 321},
            '{7'h27, 1'b1, 8'h00, 8'h00, 8'h81, 1'b1, 177},
            '{7'h50, 1'b0, 8'hFF, 8'h00, 8'h81, 1'b0, 321}
        };

        repeat (3) @(negedge clk);
        chk("rst_scl", scl, 1);
        chk("rst_sda", sda, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ack_err", ack_err, 0);
        chk("rst_rdata", rdata, 8'h00);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(tbl[i]);

        // start pulsed mid-transaction and again in the done cycle
        d0 = done_cnt;
        launch(7'h50, 1'b0, 8'h5A, 8'h00);
        repeat (50) @(negedge clk);
        addr = 7'h27; rw = 1'b1; wdata = 8'h11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        chk("busy_start_latency", lat, 321);
        chk("busy_start_ack_err", ack_err, 0);
        addr = 7'h27; rw = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_done_ignored", busy, 0);
        repeat (20) @(negedge clk);
        chk("busy_start_done_pulses", done_cnt - d0, 1);
        chk("busy_start_events_left", exp_q.size(), 0);

        // reset while the data byte is on the bus, SCL low
        launch(7'h50, 1'b0, 8'hA5, 8'h00);
        repeat (193) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_scl", scl, 1);
        chk("midrst_sda", sda, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_ack_err", ack_err, 0);
        chk("midrst_rdata", rdata, 8'h00);
        rst = 1'b0;
        exp_q.delete();
        repeat (4) @(negedge clk);
        v = '{7'h50, 1'b0, 8'h3C, 8'h00, 8'h00, 1'b0, 321};
        run_vec(v);

`ifdef I2C_MASTER_STRETCH_EN
        stretch_on = 1'b1;
        v = '{7'h50, 1'b0, 8'hA5, 8'h00, 8'h00, 1'b0, 341};
        run_vec(v);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_master.md
Name: i2c_master

Overview:
- Single-byte I2C bus master; sits directly upstream of the team's I2C slave and drives its SCL/SDA pins.
- A host command-pulse interface issues one complete transaction:
  - START
  - 7-bit address + R/W bit
  - address ACK check
  - one data byte, written or read
  - STOP
- Generates SCL from the system clock. Reports read data, completion and ACK errors to the host.

Parameters:
- CLK_DIV, 4, system clk cycles per quarter SCL period (≥2). SCL period = 4*CLK_DIV clk cycles.

Ports:
- clk  input  1  system clock; all logic on posedge clk
- rst  input  1  synchronous, active-high reset, sampled on posedge clk
- start  input  1  one-cycle command strobe; accepted only when busy=0
- addr  input  7  target slave address, captured on accepted start
- rw  input  1  0=write, 1=read; captured on accepted start
- wdata  input  8  write byte; captured on accepted start
- rdata  output  8  byte read from slave; valid while done=1 and held until next accepted start
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse at transaction end
- ack_err  output  1  set at done if the address or write-data ACK was NACK; cleared on next accepted start
- scl  inout  1  I2C clock
- sda  inout  1  I2C data; open-drain: driven 0 or released to 'z' only, never driven 1

Behaviour:
- Reset values:
  - scl=1, sda released
  - rdata=0, busy=0, done=0, ack_err=0
  - FSM=IDLE, divider=0
- Reset mid-transaction aborts immediately; no STOP is generated.
- Quarter-tick divider: emits qtick every CLK_DIV clk cycles while busy. Held at 0 in IDLE.
- Each bit occupies four quarters, advanced on qtick:
  - Q0: SCL low; SDA updated here only.
  - Q1: SCL rises.
  - Q2: SCL high; SDA sampled.
  - Q3: SCL falls.
- SDA is held stable across the full high phase and through the falling edge. This is required because the slave samples on negedge SCL.
- FSM states:
  - IDLE → START on start&&!busy. Inputs are captured.
  - START: SDA falls while SCL=1 (4 quarters). SCL is low on exit.
  - ADDR: 8 bits, MSB first: addr[6:0], then rw.
  - ADDR_ACK: SDA released; sample at Q2. If 0 → WRITE or READ by rw. If 1 → ack_err=1, go to STOP.
  - WRITE: 8 bits wdata, MSB first.
  - WRITE_ACK: sample; if 1, ack_err=1. Go to STOP.
  - READ: SDA released; sample 8 bits MSB first into shift register.
  - READ_NACK: master releases SDA (NACK, final byte). Go to STOP.
  - STOP: Q0 SDA low, Q1 SCL high, Q2 SDA released (rising while SCL=1), Q3 idle.
  - DONE: one clk; done=1, rdata updated (read), busy=0 next cycle; → IDLE.
- Latency for a full transaction:
  - 4+36+36+4 = 80 quarters.
  - done asserts 80*CLK_DIV+1 cycles after the start strobe, measured from the strobe cycle to the done cycle.
- Address NACK: 4+36+4 = 44 quarters, +1 cycle.
- start while busy: ignored; no queuing.
- start and done in the same cycle: start is ignored. busy drops the next cycle.
- Bit counter is 3 bits and wraps 7→0 on byte end.

Optional Feature:
- I2C_MASTER_STRETCH_EN: clock stretching.
  - With the macro defined, SCL is open-drain (0 or 'z').
  - At Q1/Q2 the FSM and divider stall while the scl pin reads 0. They resume counting from the cycle SCL is seen high.
  - Without the macro, SCL is driven push-pull 0/1 and never sampled; timing is exactly as above.

Decomposition:
- Package i2c_pkg holds:
  - FSM state enum: IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_NACK, STOP, DONE
  - quarter-phase constants Q0–Q3
  - I2C_RW_WRITE=0, I2C_RW_READ=1
- Sub-module i2c_clk_gen: quarter-tick divider with enable and (under the macro) stall input, outputs qtick and phase[1:0].

Test Plan:
- Write, addr=0x50 rw=0 wdata=0xA5, ACKing slave model, CLK_DIV=4:
  - Bus shows START, 0xA0, ACK, 0xA5, ACK, STOP.
  - done at cycle 321; ack_err=0.
- Read, addr=0x50 rw=1, slave returns 0x3C:
  - rdata=0x3C at done; 9th data bit SDA=1 (NACK).
  - STOP follows; ack_err=0.
- Address NACK, addr=0x27 (no slave):
  - ack_err=1; no data clocks; STOP issued; done at cycle 177.
- start pulsed while busy with different addr:
  - Ignored; bus traffic matches the first command only.
  - done pulses exactly once.
- rst asserted mid-WRITE:
  - Next cycle scl=1, sda='z', busy=0, done=0, ack_err=0.
  - A new start then produces a clean transaction.
- With I2C_MASTER_STRETCH_EN, slave holds SCL low 20 cycles after the address ACK:
  - Master stalls; done delayed by exactly 20 cycles vs baseline; data unchanged.
